ffbank_multi: RTL and testbench

Parametrised bank of WIDTH independent flip-flop channels sharing one clock. A runtime mode selects SR, JK, D or T behaviour for all channels. Unlike a plain SR flip-flop, the forbidden SR input (s=r=1) never drives X: the channel holds and the event is recorded in sticky per-channel error flags and a saturating error counter. The block is the general-purpose storage primitive for the sequential-circuits library, used wherever a configurable-width latchable register with change detection is needed.

---
 rtl/ffbank_multi.sv | 125 ++++++++++++
 tb/tb_ffbank_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ffbank_multi.sv
// ffbank_multi: WIDTH independent flip-flop channels on one clock. A runtime
// mode selects SR, JK, D or T behaviour for every channel. The forbidden SR
// input (s=r=1) holds the channel instead of producing X. Each such event
// sets a sticky per-channel error flag and bumps a saturating event counter.
module ffbank_multi #(
  parameter int                 WIDTH     = 4,
  parameter int                 CNT_W     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic [WIDTH-1:0]  chg,
  output logic [WIDTH-1:0]  err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_forbid;
  logic             w_any_forbid;
  logic [CNT_W-1:0] w_cnt_next;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  // Per-channel next state for the selected mode; everything holds when en=0.
  always_comb begin
    w_q_next = r_q;
    w_forbid = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (mode)
          MODE_SR: begin
            if (a[i] && b[i]) begin
              w_forbid[i] = 1'b1;
            end else if (a[i]) begin
              w_q_next[i] = 1'b1;
            end else if (b[i]) begin
              w_q_next[i] = 1'b0;
            end
          end
          MODE_JK: begin
            if (a[i] && b[i]) begin
              w_q_next[i] = ~r_q[i];
            end else if (a[i]) begin
              w_q_next[i] = 1'b1;
            end else if (b[i]) begin
              w_q_next[i] = 1'b0;
            end
          end
          MODE_D: begin
            w_q_next[i] = a[i];
          end
          MODE_T: begin
            if (a[i]) begin
              w_q_next[i] = ~r_q[i];
            end
          end
          default: begin
            w_q_next[i] = r_q[i];
          end
        endcase
      end
    end
  end

  assign w_any_forbid = |w_forbid;

  // Counter next value: a clear restarts the count, but an error on the
  // clearing edge is still counted as the first event of the new window.
  always_comb begin
    w_cnt_next = r_cnt;
    if (err_clr) begin
      w_cnt_next = w_any_forbid ? CNT_ONE : '0;
    end else if (w_any_forbid) begin
      w_cnt_next = sat_inc(r_cnt);
    end
  end

  // State, change flags and error bookkeeping, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= RESET_VAL;
      r_chg <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_chg <= w_q_next ^ r_q;
      r_err <= err_clr ? w_forbid : (r_err | w_forbid);
      r_cnt <= w_cnt_next;
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign chg     = r_chg;
  assign err     = r_err;
  assign err_cnt = r_cnt;

endmodule

// File: tb/tb_ffbank_multi.sv
// Bench for ffbank_multi: directed scenarios with fixed expected values, then
// randomized traffic checked against a per-channel behavioural model. Two
// instances share all inputs; the second has a 2-bit counter for saturation.
module tb_ffbank_multi;

  localparam int         W    = 4;
  localparam logic [3:0] RSTV = 4'b1010;

  logic       clk = 1'b0;
  logic       rst_n, en, err_clr;
  logic [1:0] mode;
  logic [3:0] a, b;

  logic [3:0] q, qbar, chg, err;
  logic [7:0] err_cnt;
  logic [3:0] s_q, s_qbar, s_chg, s_err;
  logic [1:0] s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [3:0] m_q, m_chg, m_err;
  int         m_cnt, m_cnt2;

  ffbank_multi #(.WIDTH(W), .CNT_W(8), .RESET_VAL(RSTV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q), .qbar(qbar), .chg(chg), .err(err),
    .err_cnt(err_cnt)
  );

  ffbank_multi #(.WIDTH(W), .CNT_W(2), .RESET_VAL(RSTV)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(s_q), .qbar(s_qbar), .chg(s_chg), .err(s_err),
    .err_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  // Apply one set of inputs, advance the model, clock once, settle.
  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] ai, input logic [3:0] bi,
                       input logic c);
    logic [3:0] nq, forb;
    rst_n = r; en = e; mode = m; a = ai; b = bi; err_clr = c;
    if (!r) begin
      m_q = RSTV; m_chg = '0; m_err = '0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      nq = m_q;
      forb = '0;
      if (e) begin
        for (int i = 0; i < W; i++) begin
          if (m == 2'd0) begin
            if (ai[i] && bi[i]) forb[i] = 1'b1;
            else if (ai[i])     nq[i] = 1'b1;
            else if (bi[i])     nq[i] = 1'b0;
          end else if (m == 2'd1) begin
            if (ai[i] && bi[i]) nq[i] = !m_q[i];
            else if (ai[i])     nq[i] = 1'b1;
            else if (bi[i])     nq[i] = 1'b0;
          end else if (m == 2'd2) begin
            nq[i] = ai[i];
          end else begin
            if (ai[i]) nq[i] = !m_q[i];
          end
        end
      end
      m_chg = nq ^ m_q;
      m_q   = nq;
      if (c) begin
        m_err  = forb;
        m_cnt  = (forb != 0) ? 1 : 0;
        m_cnt2 = (forb != 0) ? 1 : 0;
      end else begin
        m_err = m_err | forb;
        if (forb != 0 && m_cnt < 255) m_cnt++;
        if (forb != 0 && m_cnt2 < 3)  m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
    n_cmp++; if (q !== 4'b1010) begin n_bad++; $display("FAIL reset_q got %b want 1010", q); end
    n_cmp++; if (qbar !== 4'b0101) begin n_bad++; $display("FAIL reset_qbar got %b want 0101", qbar); end
    n_cmp++; if (chg !== 4'b0000) begin n_bad++; $display("FAIL reset_chg got %b want 0000", chg); end
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL reset_err got %b want 0000", err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_sr;
    drive(1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0); // D load of 0000
    n_cmp++; if (q !== 4'b0000 || chg !== 4'b1010) begin n_bad++; $display("FAIL d_clear q=%b chg=%b want 0000/1010", q, chg); end
    drive(1'b1, 1'b1, 2'd0, 4'b0011, 4'b0101, 1'b0);
    n_cmp++; if (q !== 4'b0010) begin n_bad++; $display("FAIL sr1_q got %b want 0010", q); end
    n_cmp++; if (chg !== 4'b0010) begin n_bad++; $display("FAIL sr1_chg got %b want 0010", chg); end
    n_cmp++; if (err !== 4'b0001) begin n_bad++; $display("FAIL sr1_err got %b want 0001", err); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL sr1_cnt got %0d want 1", err_cnt); end
    drive(1'b1, 1'b1, 2'd0, 4'b0011, 4'b0101, 1'b0);
    n_cmp++; if (q !== 4'b0010 || chg !== 4'b0000) begin n_bad++; $display("FAIL sr2 q=%b chg=%b want 0010/0000", q, chg); end
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL sr2_cnt got %0d want 2", err_cnt); end
  endtask

  task automatic test_jk_t;
    drive(1'b1, 1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0);
    n_cmp++; if (q !== 4'b1101 || chg !== 4'b1111) begin n_bad++; $display("FAIL jk q=%b chg=%b want 1101/1111", q, chg); end
    drive(1'b1, 1'b1, 2'd3, 4'b1000, 4'b0111, 1'b0);
    n_cmp++; if (q !== 4'b0101 || chg !== 4'b1000) begin n_bad++; $display("FAIL t q=%b chg=%b want 0101/1000", q, chg); end
    n_cmp++; if (err !== 4'b0001 || err_cnt !== 8'd2) begin n_bad++; $display("FAIL t_err err=%b cnt=%0d want 0001/2", err, err_cnt); end
  endtask

  task automatic test_d_enable;
    drive(1'b1, 1'b0, 2'd2, 4'b1111, 4'b0000, 1'b0);
    n_cmp++; if (q !== 4'b0101 || chg !== 4'b0000) begin n_bad++; $display("FAIL d_hold q=%b chg=%b want 0101/0000", q, chg); end
    drive(1'b1, 1'b1, 2'd2, 4'b1111, 4'b0000, 1'b0);
    n_cmp++; if (q !== 4'b1111 || chg !== 4'b1010) begin n_bad++; $display("FAIL d_load q=%b chg=%b want 1111/1010", q, chg); end
  endtask

  task automatic test_clear;
    drive(1'b1, 1'b1, 2'd0, 4'b0100, 4'b0100, 1'b1);
    n_cmp++; if (err !== 4'b0100 || err_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_new err=%b cnt=%0d want 0100/1", err, err_cnt); end
    n_cmp++; if (q !== 4'b1111) begin n_bad++; $display("FAIL clr_q got %b want 1111", q); end
    drive(1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1);
    n_cmp++; if (err !== 4'b0000 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_plain err=%b cnt=%0d want 0000/0", err, err_cnt); end
  endtask

  task automatic test_saturation;
    int exp_seq [4] = '{1, 2, 3, 3};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0);
      n_cmp++; if (int'(s_cnt) !== exp_seq[k]) begin n_bad++; $display("FAIL sat_step%0d got %0d want %0d", k, s_cnt, exp_seq[k]); end
    end
    n_cmp++; if (err_cnt !== 8'd4) begin n_bad++; $display("FAIL wide_cnt got %0d want 4", err_cnt); end
    drive(1'b1, 1'b1, 2'd0, 4'b0010, 4'b0010, 1'b1); // clear at saturation with new error
    n_cmp++; if (s_cnt !== 2'd1) begin n_bad++; $display("FAIL sat_clr got %0d want 1", s_cnt); end
    drive(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 1'b0);
    n_cmp++; if (s_cnt !== 2'd0 || s_q !== RSTV) begin n_bad++; $display("FAIL sat_rst cnt=%0d q=%b want 0/1010", s_cnt, s_q); end
  endtask

  task automatic test_random;
    logic r, e, c;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 29) != 0);
      e = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 9) == 0);
      drive(r, e, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), c);
      n_cmp++;
      if (q !== m_q || qbar !== ~m_q || chg !== m_chg || err !== m_err ||
          int'(err_cnt) !== m_cnt || int'(s_cnt) !== m_cnt2 || s_q !== m_q) begin
        n_bad++;
        $display("FAIL rand%0d q=%b chg=%b err=%b cnt=%0d scnt=%0d want q=%b chg=%b err=%b cnt=%0d scnt=%0d",
                 k, q, chg, err, err_cnt, s_cnt, m_q, m_chg, m_err, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; a = '0; b = '0; err_clr = 1'b0;
    #2;
    test_reset();
    test_sr();
    test_jk_t();
    test_d_enable();
    test_clear();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
